fir_param: RTL and testbench

FIR_PARAM -- requirements
Module: fir_param

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_tap.sv | 58 +++++
 rtl/fir_param.sv | 117 +++++++++++
 tb/tb_fir_param.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared defaults and width helpers for the parameterised FIR filter.
package fir_pkg;

  localparam int NTAPS_DEF = 11;
  localparam int DW_DEF    = 13;
  localparam int CW_DEF    = 13;
  localparam int ADDR_W    = 5;

  // Wide enough to sum ntaps full-precision products without overflow.
  function automatic int acc_width(input int ntaps, input int dw, input int cw);
    return dw + cw + $clog2(ntaps);
  endfunction

endpackage

// File: rtl/fir_tap.sv
// One FIR tap: delay register, coefficient register, and registered product.
module fir_tap
  import fir_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    vin_i,
  input  logic                    we_i,
  input  logic signed [CW-1:0]    coef_i,
  input  logic signed [DW-1:0]    x_i,
  output logic signed [DW-1:0]    x_o,
  output logic signed [DW+CW-1:0] p_o
);

  localparam int PW = DW + CW;

  logic signed [DW-1:0] x_q, x_d;
  logic signed [CW-1:0] h_q, h_d;
  logic signed [PW-1:0] p_q, p_d;

  // The product is formed from the sample entering this tap and the coefficient
  // held before any same-edge write, so a write never affects the sample it meets.
  always_comb begin
    x_d = x_q;
    h_d = h_q;
    p_d = p_q;
    if (we_i) begin
      h_d = coef_i;
    end
    if (clr_i) begin
      x_d = '0;
      p_d = '0;
    end else if (vin_i) begin
      x_d = x_i;
      p_d = PW'(x_i) * PW'(h_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= '0;
      h_q <= '0;
      p_q <= '0;
    end else begin
      x_q <= x_d;
      h_q <= h_d;
      p_q <= p_d;
    end
  end

  assign x_o = x_q;
  assign p_o = p_q;

endmodule

// File: rtl/fir_param.sv
// Direct-form FIR, two pipeline stages (products, then sum/scale/reduce).
// Output reduction saturates when FIR_PARAM_SAT_EN is defined, otherwise wraps.
module fir_param
  import fir_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  parameter int DW    = DW_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic signed [DW-1:0] DIN,
  input  logic                 VIN,
  input  logic                 COEF_WE,
  input  logic [ADDR_W-1:0]    COEF_ADDR,
  input  logic signed [CW-1:0] COEF_DATA,
  input  logic                 CLR,
  output logic signed [DW-1:0] DOUT,
  output logic                 VOUT
);

  localparam int PW    = DW + CW;
  localparam int ACC_W = acc_width(NTAPS, DW, CW);

  // Stream handshake: valid-only, no ready. Every edge with VIN=1 and CLR=0
  // takes DIN; VOUT is high for one cycle per taken sample, exactly two cycles
  // later, and DOUT holds its value whenever VOUT is low.

  logic signed [DW-1:0] x_chain [NTAPS+1];
  logic signed [PW-1:0] prod    [NTAPS];
  logic [NTAPS-1:0]     tap_we;

  assign x_chain[0] = DIN;

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    assign tap_we[k] = COEF_WE && (COEF_ADDR == ADDR_W'(k));

    fir_tap #(
      .DW(DW),
      .CW(CW)
    ) u_tap (
      .clk_i (CLK),
      .rst_i (RST),
      .clr_i (CLR),
      .vin_i (VIN),
      .we_i  (tap_we[k]),
      .coef_i(COEF_DATA),
      .x_i   (x_chain[k]),
      .x_o   (x_chain[k+1]),
      .p_o   (prod[k])
    );
  end

  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] scaled;
  logic signed [DW-1:0]    red;

  always_comb begin
    acc_d = '0;
    for (int k = 0; k < NTAPS; k++) begin
      acc_d = acc_d + ACC_W'(prod[k]);
    end
  end

  // Coefficients are Q1.(CW-1), so drop CW-1 fraction bits.
  assign scaled = acc_d >>> (CW - 1);

`ifdef FIR_PARAM_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  always_comb begin
    red = DW'(scaled);
    if (scaled > SAT_MAX) begin
      red = {1'b0, {(DW-1){1'b1}}};
    end else if (scaled < SAT_MIN) begin
      red = {1'b1, {(DW-1){1'b0}}};
    end
  end
`else
  assign red = DW'(scaled);
`endif

  logic                 v1_q, v1_d;
  logic                 vout_q, vout_d;
  logic signed [DW-1:0] dout_q, dout_d;

  always_comb begin
    v1_d   = VIN;
    vout_d = v1_q;
    dout_d = dout_q;
    if (v1_q) begin
      dout_d = red;
    end
    if (CLR) begin
      v1_d   = 1'b0;
      vout_d = 1'b0;
      dout_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      v1_q   <= 1'b0;
      vout_q <= 1'b0;
      dout_q <= '0;
    end else begin
      v1_q   <= v1_d;
      vout_q <= vout_d;
      dout_q <= dout_d;
    end
  end

  assign DOUT = dout_q;
  assign VOUT = vout_q;

endmodule

// File: tb/tb_fir_param.sv
// Directed, table-driven bench for fir_param (NTAPS=11, DW=CW=13).
module tb_fir_param;

  localparam int NT = 11;
  localparam int DW = 13;
  localparam int CW = 13;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] din;
  logic                 vin;
  logic                 coef_we;
  logic [4:0]           coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 clr;
  logic signed [DW-1:0] dout;
  logic                 vout;

  always #5 clk = ~clk;

  fir_param #(
    .NTAPS(NT),
    .DW   (DW),
    .CW   (CW)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .DIN      (din),
    .VIN      (vin),
    .COEF_WE  (coef_we),
    .COEF_ADDR(coef_addr),
    .COEF_DATA(coef_data),
    .CLR      (clr),
    .DOUT     (dout),
    .VOUT     (vout)
  );

  // One record per clock cycle: inputs driven in that cycle, and the outputs
  // expected to be visible during that same cycle (before its rising edge).
  typedef struct {
    logic                 rst;
    logic                 clr;
    logic                 vin;
    logic signed [DW-1:0] din;
    logic                 we;
    logic [4:0]           addr;
    logic signed [CW-1:0] data;
    logic                 chk;
    logic                 exp_vout;
    logic signed [DW-1:0] exp_dout;
  } vec_t;

  vec_t       tbl[$];
  logic [DW:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  initial begin
    #2000000;
    $display("FAIL timeout: vectors=%0d, required completion", n_vec);
    $fatal(1, "bench timeout");
  end

  task automatic pv(input logic vin_v, input int din_v, input logic chk_v,
                    input logic ev, input int ed);
    vec_t v;
    v.rst = 1'b0; v.clr = 1'b0; v.vin = vin_v; v.din = DW'(din_v);
    v.we = 1'b0; v.addr = '0; v.data = '0;
    v.chk = chk_v; v.exp_vout = ev; v.exp_dout = DW'(ed);
    tbl.push_back(v);
  endtask

  task automatic last_ctl(input logic r, input logic c, input logic w,
                          input int a, input int d);
    int i;
    i = tbl.size() - 1;
    tbl[i].rst  = r;
    tbl[i].clr  = c;
    tbl[i].we   = w;
    tbl[i].addr = 5'(a);
    tbl[i].data = CW'(d);
  endtask

  task automatic do_cycle(input vec_t v, input string name, input int idx);
    logic [DW:0] e;
    @(negedge clk);
    if (v.chk) begin
      e = exp_q.pop_front();
      n_vec++;
      if ({vout, dout} !== e) begin
        n_bad++;
        $display("FAIL %s[%0d]: got vout=%0b dout=%0d, expected vout=%0b dout=%0d",
                 name, idx, vout, dout, e[DW], $signed(e[DW-1:0]));
      end
    end
    rst       = v.rst;
    clr       = v.clr;
    vin       = v.vin;
    din       = v.din;
    coef_we   = v.we;
    coef_addr = v.addr;
    coef_data = v.data;
  endtask

  task automatic run_table(input string name);
    foreach (tbl[i]) begin
      if (tbl[i].chk) exp_q.push_back({tbl[i].exp_vout, tbl[i].exp_dout});
    end
    for (int i = 0; i < tbl.size(); i++) do_cycle(tbl[i], name, i);
    tbl.delete();
  endtask

  task automatic ld_coef(input int a, input int d);
    vec_t v;
    v.rst = 1'b0; v.clr = 1'b0; v.vin = 1'b0; v.din = '0;
    v.we = 1'b1; v.addr = 5'(a); v.data = CW'(d);
    v.chk = 1'b0; v.exp_vout = 1'b0; v.exp_dout = '0;
    do_cycle(v, "load", a);
  endtask

  // Flush the delay line and output, then two idle cycles so DOUT=0, VOUT=0.
  task automatic prep();
    vec_t v;
    v.rst = 1'b0; v.clr = 1'b1; v.vin = 1'b0; v.din = '0;
    v.we = 1'b0; v.addr = '0; v.data = '0;
    v.chk = 1'b0; v.exp_vout = 1'b0; v.exp_dout = '0;
    do_cycle(v, "prep", 0);
    v.clr = 1'b0;
    do_cycle(v, "prep", 1);
    do_cycle(v, "prep", 2);
  endtask

  initial begin
    int ev_a[14];
    int ed_a[14];
    int last_ed;
    int j;
    rst = 1'b1; clr = 1'b0; vin = 1'b0; din = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;

    // Reset: inputs during RST ignored, outputs cleared.
    pv(1, 1000, 0, 0, 0); last_ctl(1, 1, 1, 0, 5);
    pv(1, 1000, 1, 0, 0); last_ctl(1, 0, 1, 0, 5);
    pv(0, 0, 1, 0, 0);
    pv(0, 0, 1, 0, 0);
    pv(0, 0, 1, 0, 0);
    run_table("reset");

    // Impulse with continuous VIN: h[k]=100*(k+1), 2048 -> 50*(k+1).
    for (int k = 0; k < NT; k++) ld_coef(k, 100 * (k + 1));
    prep();
    for (int r = 0; r <= 16; r++) begin
      pv(r <= 12, (r == 0) ? 2048 : 0, 1, (r >= 2 && r <= 14),
         (r >= 2 && r <= 12) ? 50 * (r - 1) : 0);
    end
    run_table("impulse");

    // Same impulse with VIN every other cycle; junk DIN on idle cycles.
    prep();
    last_ed = 0;
    for (int r = 0; r <= 25; r++) begin
      logic v_in, v_out;
      int   e_d;
      v_in  = (r % 2 == 0) && (r <= 22);
      v_out = (r >= 2) && ((r - 2) % 2 == 0) && (r <= 24);
      e_d   = last_ed;
      if (v_out) begin
        j   = (r - 2) / 2;
        e_d = (j <= 10) ? 50 * (j + 1) : 0;
      end
      pv(v_in, (r == 0) ? 2048 : (v_in ? 0 : 777), 1, v_out, e_d);
      last_ed = e_d;
    end
    run_table("gapped");

    // Out-of-range writes ignored; h[0] write on the VIN cycle uses the old h[0].
    prep();
    for (int r = 0; r <= 17; r++) begin
      int e_d;
      j   = r - 4;
      e_d = 0;
      if (j == 0)                 e_d = 50;
      else if (j == 1)            e_d = 200;
      else if (j >= 2 && j <= 10) e_d = 50 * (2 * j + 1);
      else if (j == 11)           e_d = 550;
      pv(r >= 2 && r <= 14, (r == 2 || r == 3) ? 2048 : 0, 1, (j >= 0 && j <= 12), e_d);
      if (r == 0) last_ctl(0, 0, 1, 11, 4000);
      if (r == 1) last_ctl(0, 0, 1, 16, 4000);
      if (r == 2) last_ctl(0, 0, 1, 0, 200);
    end
    run_table("coef_write");

    // CLR mid-stream with a simultaneous h[0]=300 write; DIN=2048 continuous.
    ld_coef(0, 100);
    prep();
    ev_a = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0};
    ed_a = '{0, 0, 50, 150, 300, 500, 0, 0, 150, 250, 400, 600, 600, 600};
    for (int r = 0; r < 14; r++) begin
      pv(r <= 9, 2048, 1, ev_a[r] != 0, ed_a[r]);
      if (r == 5) last_ctl(0, 1, 1, 0, 300);
    end
    run_table("clr");

    // RST mid-stream: pipeline discarded and coefficients zeroed.
    prep();
    ev_a = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0};
    ed_a = '{0, 0, 150, 250, 400, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int r = 0; r < 12; r++) begin
      pv(r <= 8, 2048, 1, ev_a[r] != 0, ed_a[r]);
      if (r == 4) last_ctl(1, 0, 1, 1, 500);
    end
    run_table("rst");

    // Overflow: all h=4095, DIN=-4096; sum/4096 = -4095*(samples in line).
    for (int k = 0; k < NT; k++) ld_coef(k, 4095);
    prep();
    for (int r = 0; r <= 13; r++) begin
      int e_d;
      logic c;
      c   = (r == 2) || (r == 3) || (r == 12) || (r == 13);
      e_d = -4095;
`ifdef FIR_PARAM_SAT_EN
      if (r >= 3) e_d = -4096;
`else
      if (r == 3)  e_d = 2;
      if (r >= 12) e_d = -4085;
`endif
      pv(r <= 10, -4096, c, r <= 12, e_d);
    end
    run_table("overflow");

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
